soc_system_pio_poll_master: RTL and testbench
=============================================

// Module: soc_system_pio_poll_master
// PURPOSE
//  Avalon-MM read initiator that polls a read-only input-PIO slave (one readdata register at word 0).
//  Issues a read every INTERVAL+1 idle cycles and honours waitrequest and a fixed read latency.
//  Presents each captured word to fabric logic with a valid strobe and a change-detect strobe.
//  Sits in the FPGA fabric beside the HPS-visible PIOs so fabric logic can observe the same status words.
// PARAMETERS
//  DATA_W        32    readdata / sample width
//  ADDR_W        2     avm_address width
//  POLL_ADDR     0     word address read on every poll
//  READ_LATENCY  1     cycles from read acceptance to readdata valid (1..4)
//  CNT_W         16    width of interval counter and interval input
//  TIMEOUT       255   max cycles read may be stalled by waitrequest before timeout_err sets
// PORTS
//  clk              in   1        single clock domain
//  reset            in   1        synchronous, active-high
//  enable           in   1        1 = keep polling; 0 = finish current read, then idle
//  interval         in   CNT_W    idle cycles between polls; sampled on entry to WAIT
//  clear_err        in   1        clears timeout_err
//  avm_address      out  ADDR_W   constant POLL_ADDR
//  avm_read         out  1        read request
//  avm_waitrequest  in   1        slave stall
//  avm_readdata     in   DATA_W   valid READ_LATENCY cycles after acceptance
//  sample_data      out  DATA_W   last captured word
//  sample_valid     out  1        1-cycle pulse when sample_data updates
//  changed          out  1        1-cycle pulse with sample_valid if new word != previous word
//  busy             out  1        1 while in READ or LAT
//  timeout_err      out  1        sticky stall-timeout flag
// BEHAVIOUR
//  Reset: state IDLE; avm_read=0; sample_data=0; sample_valid=0; changed=0; timeout_err=0; have_prev=0.
//  avm_address is hard-tied to POLL_ADDR; no write signals are driven.
//  FSM states: IDLE, WAIT, READ, LAT.
//   IDLE: if enable -> WAIT; load cnt=interval.
//   WAIT: if !enable -> IDLE; elif cnt==0 -> READ; else cnt--.
//   READ: avm_read=1; held until accepted (avm_read & !avm_waitrequest) -> LAT; lat_cnt=READ_LATENCY-1.
//   LAT:  avm_read=0; when lat_cnt==0, capture avm_readdata that cycle. Else lat_cnt--.
//         After capture: -> WAIT if enable (reload cnt=interval), else IDLE.
//  Capture cycle: sample_data<=avm_readdata; sample_valid<=1 next cycle (registered, 1 pulse).
//  Changed: changed<=have_prev & (avm_readdata!=sample_data); then have_prev<=1.
//   The first sample after reset never asserts changed.
//  Poll period: interval + READ_LATENCY + 2 cycles with zero stall. For interval=0, latency=1: one read every 3 cycles.
//  Avalon rule: once asserted, avm_read is never dropped before acceptance, even if enable falls or timeout fires.
//  enable falling during READ/LAT: the transaction completes and the sample is delivered, then IDLE.
//  Timeout: stall counter (8b, saturating) counts READ cycles with waitrequest=1.
//   timeout_err sets when the count reaches TIMEOUT; the read stays asserted.
//   clear_err clears the flag; clear_err and a set condition in the same cycle -> set wins.
//  interval changes take effect only at the next WAIT entry; the current countdown is unaffected.
//  Reset mid-transaction: immediate return to reset values.
//   No readdata from a read accepted before reset is captured.
//  Width: all counters unsigned; cnt decrements to 0 only (no wrap).
// STRUCTURE
//  Package soc_pio_pkg: state enum (IDLE,WAIT,READ,LAT), localparam STALL_W=8, PIO_DATA_W=32.
//  Single module; no sub-modules. Change detect and capture stay inline.
// TESTING
//  1. enable=1, interval=0, zero-wait slave returning 0x0000_00A5 at latency 1
//     -> avm_read every 3rd cycle; first sample_valid has sample_data=0xA5 and changed=0.
//  2. Slave data 0x1 then 0x2 on consecutive polls -> second sample_valid has changed=1;
//     a repeat of 0x2 -> changed=0.
//  3. interval=5 -> consecutive avm_read rising edges exactly 5+1+2=8 cycles apart.
//  4. waitrequest held 300 cycles -> timeout_err=1 at stall count 255; avm_read held throughout;
//     sample delivered after release; clear_err -> timeout_err=0.
//  5. Drop enable during LAT -> sample_valid still pulses once, then IDLE, no further avm_read.
//  6. Assert reset during LAT -> all outputs return to reset values next cycle; no sample_valid;
//     after reset, first poll has changed=0.

Source files
------------

// File: rtl/soc_pio_pkg.sv
// soc_pio_pkg
//   Shared types and constants for the PIO poll master.
//   poll_state_e : poll FSM states (IDLE, WAIT, READ, LAT)
//   STALL_W      : width of the saturating waitrequest stall counter
//   PIO_DATA_W   : natural width of an input-PIO readdata word
package soc_pio_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    READ,
    LAT
  } poll_state_e;

  localparam int STALL_W    = 8;
  localparam int PIO_DATA_W = 32;

endpackage

// File: rtl/soc_system_pio_poll_master.sv
// soc_system_pio_poll_master
//   Avalon-MM read initiator that periodically polls word POLL_ADDR of a
//   read-only input-PIO slave and hands each captured word to fabric logic.
//   Ports:
//     clk, reset        single clock, synchronous active-high reset
//     enable            keep polling while high; a read in flight always completes
//     interval          idle cycles between polls, sampled on entry to WAIT
//     clear_err         clears the sticky timeout flag (a new timeout wins)
//     avm_address       constant POLL_ADDR
//     avm_read          read request, held until accepted
//     avm_waitrequest   slave stall
//     avm_readdata      read data, valid READ_LATENCY cycles after acceptance
//     sample_data       last captured word
//     sample_valid      one-cycle pulse when sample_data updates
//     changed           pulses with sample_valid when the word differs from the previous one
//     busy              high while a read is outstanding (READ or LAT)
//     timeout_err       sticky flag: a read was stalled TIMEOUT cycles
module soc_system_pio_poll_master
  import soc_pio_pkg::*;
#(
  parameter int DATA_W       = PIO_DATA_W,
  parameter int ADDR_W       = 2,
  parameter int POLL_ADDR    = 0,
  parameter int READ_LATENCY = 1,
  parameter int CNT_W        = 16,
  parameter int TIMEOUT      = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [CNT_W-1:0]  interval,
  input  logic              clear_err,
  output logic [ADDR_W-1:0] avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [DATA_W-1:0] avm_readdata,
  output logic [DATA_W-1:0] sample_data,
  output logic              sample_valid,
  output logic              changed,
  output logic              busy,
  output logic              timeout_err
);

  // Latency of 1..4 fits a 2-bit down-counter holding READ_LATENCY-1.
  localparam int                 LAT_W       = 2;
  localparam logic [LAT_W-1:0]   LAT_INIT    = LAT_W'(READ_LATENCY - 1);
  localparam logic [STALL_W-1:0] STALL_MAX   = '1;
  localparam logic [STALL_W-1:0] STALL_LIMIT = STALL_W'(TIMEOUT);

  poll_state_e        state;
  logic [CNT_W-1:0]   cnt;
  logic [LAT_W-1:0]   lat_cnt;
  logic [STALL_W-1:0] stall_cnt;
  logic               have_prev;

  logic               accepted;
  logic [STALL_W-1:0] stall_next;
  logic               stall_set;

  // The slave has a single register, so the address never moves.
  assign avm_address = ADDR_W'(POLL_ADDR);
  assign busy        = (state == READ) || (state == LAT);

  // Stall bookkeeping: the counter saturates instead of wrapping so that a
  // very long stall can never appear to drop back under the limit.
  assign accepted   = avm_read && !avm_waitrequest;
  assign stall_next = (stall_cnt == STALL_MAX) ? stall_cnt : stall_cnt + STALL_W'(1);
  assign stall_set  = (state == READ) && avm_waitrequest && (stall_next >= STALL_LIMIT);

  // Poll FSM with registered bus and sample outputs.  avm_read is raised on
  // the way into READ and only lowered on acceptance, so neither enable nor a
  // timeout can withdraw a pending request.  Capture and change detection
  // happen in the last LAT cycle, when the slave's readdata is valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_cnt      <= '0;
      stall_cnt    <= '0;
      have_prev    <= 1'b0;
      avm_read     <= 1'b0;
      sample_data  <= '0;
      sample_valid <= 1'b0;
      changed      <= 1'b0;
      timeout_err  <= 1'b0;
    end else begin
      sample_valid <= 1'b0;
      changed      <= 1'b0;

      if (stall_set) begin
        timeout_err <= 1'b1;
      end else if (clear_err) begin
        timeout_err <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (enable) begin
            state <= WAIT;
            cnt   <= interval;
          end
        end

        WAIT: begin
          if (!enable) begin
            state <= IDLE;
          end else if (cnt == '0) begin
            state     <= READ;
            avm_read  <= 1'b1;
            stall_cnt <= '0;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end

        READ: begin
          if (accepted) begin
            state    <= LAT;
            avm_read <= 1'b0;
            lat_cnt  <= LAT_INIT;
          end else if (avm_waitrequest) begin
            stall_cnt <= stall_next;
          end
        end

        LAT: begin
          if (lat_cnt == '0) begin
            sample_data  <= avm_readdata;
            sample_valid <= 1'b1;
            changed      <= have_prev && (avm_readdata != sample_data);
            have_prev    <= 1'b1;
            if (enable) begin
              state <= WAIT;
              cnt   <= interval;
            end else begin
              state <= IDLE;
            end
          end else begin
            lat_cnt <= lat_cnt - LAT_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_soc_system_pio_poll_master.sv
// tb_soc_system_pio_poll_master
//   Directed bench for the PIO poll master.  A small slave responder returns
//   slave_word one cycle after each accepted read (garbage otherwise), a
//   cycle-level behavioural model predicts every output, and the directed
//   sequence adds hand-computed checks on periods, timeout count and reset.
module tb_soc_system_pio_poll_master;

  localparam int DATA_W  = 32;
  localparam int CNT_W   = 16;
  localparam int TIMEOUT = 255;
  localparam int RD_LAT  = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic              enable;
  logic [CNT_W-1:0]  interval;
  logic              clear_err;
  logic [1:0]        avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [DATA_W-1:0] avm_readdata;
  logic [DATA_W-1:0] sample_data;
  logic              sample_valid;
  logic              changed;
  logic              busy;
  logic              timeout_err;

  logic [DATA_W-1:0] slave_word;
  int                checks   = 0;
  int                failures = 0;
  int                cyc      = 0;
  int                rise_q[$];
  logic              prev_read = 1'b0;

  soc_system_pio_poll_master #(
    .DATA_W(DATA_W), .ADDR_W(2), .POLL_ADDR(0), .READ_LATENCY(RD_LAT),
    .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .interval(interval),
    .clear_err(clear_err), .avm_address(avm_address), .avm_read(avm_read),
    .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
    .sample_data(sample_data), .sample_valid(sample_valid), .changed(changed),
    .busy(busy), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // Slave responder: data is only valid exactly one cycle after acceptance.
  always @(posedge clk) begin
    avm_readdata <= (avm_read && !avm_waitrequest) ? slave_word : 32'hDEAD_BEEF;
  end

  // Behavioural model: a poll is a gap of interval+1 cycles, a bus request
  // that lasts until the slave stops stalling, then RD_LAT cycles of latency.
  bit          m_waiting, m_read, m_have, m_set;
  int          m_gap, m_lat, m_stall;
  logic [31:0] e_data;
  bit          e_valid, e_chg, e_err;

  always @(posedge clk) begin
    if (reset) begin
      m_waiting = 0; m_read = 0; m_have = 0; m_gap = 0; m_lat = 0; m_stall = 0;
      e_data = 0; e_valid = 0; e_chg = 0; e_err = 0;
    end else begin
      e_valid = 0;
      e_chg   = 0;
      m_set   = 0;
      if (m_read) begin
        if (!avm_waitrequest) begin
          m_read = 0;
          m_lat  = RD_LAT;
        end else begin
          m_stall = (m_stall < 255) ? m_stall + 1 : 255;
          m_set   = (m_stall >= TIMEOUT);
        end
      end else if (m_lat > 0) begin
        m_lat = m_lat - 1;
        if (m_lat == 0) begin
          e_chg   = m_have && (avm_readdata != e_data);
          e_data  = avm_readdata;
          e_valid = 1;
          m_have  = 1;
          m_waiting = enable;
          m_gap     = int'(interval);
        end
      end else if (m_waiting) begin
        if (!enable) m_waiting = 0;
        else if (m_gap == 0) begin
          m_waiting = 0;
          m_read    = 1;
          m_stall   = 0;
        end else m_gap = m_gap - 1;
      end else if (enable) begin
        m_waiting = 1;
        m_gap     = int'(interval);
      end
      if (m_set) e_err = 1;
      else if (clear_err) e_err = 0;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h expected=%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  // Per-cycle comparison against the model, plus avm_read rising-edge log.
  always @(posedge clk) begin
    #1;
    cyc++;
    checkOutput("m_avm_read", avm_read, m_read);
    checkOutput("m_busy", busy, m_read || (m_lat > 0));
    checkOutput("m_sample_valid", sample_valid, e_valid);
    checkOutput("m_sample_data", sample_data, e_data);
    checkOutput("m_changed", changed, e_chg);
    checkOutput("m_timeout_err", timeout_err, e_err);
    checkOutput("m_avm_address", avm_address, 0);
    if (avm_read && !prev_read) rise_q.push_back(cyc);
    prev_read = avm_read;
  end

  task automatic applyStimulus(input logic en, input logic [CNT_W-1:0] intv,
                               input logic wr, input logic [31:0] word);
    enable          = en;
    interval        = intv;
    avm_waitrequest = wr;
    slave_word      = word;
  endtask

  task automatic waitValid(input int max_cyc, output bit got,
                           output logic [31:0] d, output bit c);
    got = 0; d = 0; c = 0;
    for (int i = 0; i < max_cyc && !got; i++) begin
      @(negedge clk);
      if (sample_valid) begin
        got = 1; d = sample_data; c = changed;
      end
    end
  endtask

  task automatic pollExpect(input string name, input logic [31:0] word, input bit exp_chg);
    bit got, c;
    logic [31:0] d;
    slave_word = word;
    waitValid(30, got, d, c);
    checkOutput({name, "_seen"}, got, 1);
    if (got) begin
      checkOutput({name, "_data"}, d, word);
      checkOutput({name, "_changed"}, c, exp_chg);
    end
  endtask

  task automatic waitLat(output bit found);
    found = 0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (busy && !avm_read) found = 1;
    end
  endtask

  initial begin
    bit          got, c, found, dropped;
    logic [31:0] d;
    int          en_cyc, stalled, err_at, valids;

    reset = 1'b1; clear_err = 1'b0;
    applyStimulus(1'b0, 16'd0, 1'b0, 32'h0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    checkOutput("rst_sample_data", sample_data, 0);
    checkOutput("rst_sample_valid", sample_valid, 0);
    checkOutput("rst_changed", changed, 0);
    checkOutput("rst_avm_read", avm_read, 0);
    checkOutput("rst_timeout_err", timeout_err, 0);
    checkOutput("rst_busy", busy, 0);

    // 1: interval 0, zero-wait slave -> read every 3 cycles, first sample A5.
    rise_q.delete();
    en_cyc = cyc;
    applyStimulus(1'b1, 16'd0, 1'b0, 32'h0000_00A5);
    waitValid(20, got, d, c);
    checkOutput("t1_seen", got, 1);
    checkOutput("t1_data", d, 32'hA5);
    checkOutput("t1_changed", c, 0);
    repeat (10) @(negedge clk);
    checkOutput("t1_rise_count_ok", rise_q.size() >= 3, 1);
    if (rise_q.size() >= 3) begin
      checkOutput("t1_first_read_delay", rise_q[0] - en_cyc, 2);
      checkOutput("t1_period_a", rise_q[1] - rise_q[0], 3);
      checkOutput("t1_period_b", rise_q[2] - rise_q[1], 3);
    end

    // 2: change detection.
    waitValid(20, got, d, c);
    checkOutput("t2_align", got, 1);
    pollExpect("t2_w1", 32'h1, 1'b1);
    pollExpect("t2_w2", 32'h2, 1'b1);
    pollExpect("t2_w2_repeat", 32'h2, 1'b0);

    // 3: interval 5 -> 8-cycle poll period once the new interval is loaded.
    interval = 16'd5;
    pollExpect("t3_w3", 32'h3, 1'b1);
    pollExpect("t3_w3_repeat", 32'h3, 1'b0);
    rise_q.delete();
    repeat (30) @(negedge clk);
    checkOutput("t3_rise_count_ok", rise_q.size() >= 3, 1);
    if (rise_q.size() >= 3) begin
      checkOutput("t3_period_a", rise_q[1] - rise_q[0], 8);
      checkOutput("t3_period_b", rise_q[2] - rise_q[1], 8);
    end

    // 4: 300-cycle stall -> timeout at stall count 255, read held, sample delivered.
    interval = 16'd0;
    waitValid(20, got, d, c);
    checkOutput("t4_align", got, 1);
    avm_waitrequest = 1'b1;
    slave_word      = 32'h77;
    stalled = 0; err_at = -1; dropped = 0;
    for (int i = 0; i < 400 && stalled < 300; i++) begin
      @(negedge clk);
      if (timeout_err && err_at < 0) err_at = stalled;
      if (avm_read) stalled++;
      else if (stalled > 0) dropped = 1;
    end
    checkOutput("t4_stall_reached", stalled, 300);
    checkOutput("t4_err_at_count", err_at, 255);
    checkOutput("t4_read_held", dropped, 0);
    avm_waitrequest = 1'b0;
    waitValid(10, got, d, c);
    checkOutput("t4_seen", got, 1);
    checkOutput("t4_data", d, 32'h77);
    checkOutput("t4_changed", c, 1);
    checkOutput("t4_err_sticky", timeout_err, 1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    checkOutput("t4_err_cleared", timeout_err, 0);

    // 5: enable dropped during LAT -> one last sample, then idle.
    waitLat(found);
    checkOutput("t5_lat_found", found, 1);
    enable = 1'b0;
    rise_q.delete();
    valids = 0;
    repeat (20) begin
      @(negedge clk);
      if (sample_valid) valids++;
    end
    checkOutput("t5_valid_count", valids, 1);
    checkOutput("t5_no_new_reads", rise_q.size(), 0);
    checkOutput("t5_idle_busy", busy, 0);

    // 6: reset during LAT -> reset values, no capture, first poll after reset unchanged.
    applyStimulus(1'b1, 16'd0, 1'b0, 32'h55);
    waitLat(found);
    checkOutput("t6_lat_found", found, 1);
    reset = 1'b1;
    @(negedge clk);
    checkOutput("t6_sample_valid", sample_valid, 0);
    checkOutput("t6_sample_data", sample_data, 0);
    checkOutput("t6_changed", changed, 0);
    checkOutput("t6_avm_read", avm_read, 0);
    checkOutput("t6_busy", busy, 0);
    checkOutput("t6_timeout_err", timeout_err, 0);
    reset = 1'b0;
    pollExpect("t6_first_after_reset", 32'h99, 1'b0);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
